disp_bcd_feed: RTL

Upstream feeder for the two-digit multiplexed 7-segment refresh stage. Converts an 8-bit binary value to packed two-digit BCD with a sequential double-dabble engine. Saturates values above 99. Generates the free-running one-cycle refresh enable that steps the digit multiplexer. Its InD and Cen outputs connect directly to the refresh stage's InD and Cen inputs.

---
 rtl/disp_bcd_feed.sv | 117 +++++++++++
 1 files changed

// File: rtl/disp_bcd_feed.sv
// Binary to two-digit BCD feeder for the 7-segment refresh stage.
// Sequential double-dabble conversion plus a free-running refresh strobe.
module disp_bcd_feed #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Load,
   input  logic [7:0] BinIn,
   output logic       Busy,
   output logic       Ovf,
   output logic [7:0] InD,
   output logic       Cen
);

   localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t state, next_state;

   logic [2:0]    iter;
   logic [15:0]   scratch;
   logic          ovf_pending;
   logic [DW-1:0] div_cnt;

   logic          do_load;
   logic          do_iter;
   logic          do_update;

   logic [7:0]    sat;
   logic [3:0]    units_adj;
   logic [3:0]    tens_adj;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         Busy  <= 1'b0;
      end else begin
         state <= next_state;
         Busy  <= (next_state != IDLE);
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (Load) next_state = CONV;
         CONV:    if (iter == 3'd7) next_state = UPDATE;
         UPDATE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      do_load   = 1'b0;
      do_iter   = 1'b0;
      do_update = 1'b0;
      unique case (state)
         IDLE:    do_load   = Load;
         CONV:    do_iter   = 1'b1;
         UPDATE:  do_update = 1'b1;
         default: ;
      endcase
   end

   // Saturating at 99 keeps both digits in 0..9, so no hundreds digit.
   assign sat       = (BinIn > 8'd99) ? 8'd99 : BinIn;
   assign units_adj = (scratch[11:8] >= 4'd5) ? scratch[11:8] + 4'd3
                                              : scratch[11:8];
   assign tens_adj  = (scratch[15:12] >= 4'd5) ? scratch[15:12] + 4'd3
                                               : scratch[15:12];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         scratch     <= 16'h0000;
         iter        <= 3'd0;
         ovf_pending <= 1'b0;
         InD         <= 8'h00;
         Ovf         <= 1'b0;
      end else begin
         if (do_load) begin
            scratch     <= {8'h00, sat};
            ovf_pending <= (BinIn > 8'd99);
            iter        <= 3'd0;
         end
         if (do_iter) begin
            scratch <= {tens_adj[2:0], units_adj, scratch[7:0], 1'b0};
            iter    <= iter + 3'd1;
         end
         if (do_update) begin
            InD <= scratch[15:8];
            Ovf <= ovf_pending;
         end
      end
   end

   // Refresh divider runs regardless of the conversion FSM.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         div_cnt <= '0;
         Cen     <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         Cen     <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         Cen     <= 1'b0;
      end
   end

endmodule
